// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter sharing one RAM between the data (load/store) port
// and the instruction-fetch port, with a starvation bound for fetch.
module ram_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    input  logic                f_req_i,
    input  logic [ADDR_W-1:0]   f_addr_i,
    output logic                f_gnt_o,
    output logic                f_rvalid_o,
    output logic [DATA_W-1:0]   f_rdata_o,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [DATA_W/8-1:0] ram_be_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_D_RD,
        OWN_F_RD
    } owner_t;

    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_win;
    logic             f_win;

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        f_win = rst_n & f_req_i & (~d_req_i | (starve_cnt == STARVE_LIM));
        d_win = rst_n & d_req_i & ~f_win;
    end

    always_comb begin
        d_gnt_o     = d_win;
        f_gnt_o     = f_win;
        ram_en_o    = d_win | f_win;
        ram_we_o    = d_win & d_we_i;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (d_win) begin
            ram_be_o    = d_be_i;
            ram_addr_o  = d_addr_i;
            ram_wdata_o = d_wdata_i;
        end else if (f_win) begin
            ram_addr_o  = f_addr_i;
        end
    end

    always_comb begin
        d_rvalid_o = (owner == OWN_D_RD);
        f_rvalid_o = (owner == OWN_F_RD);
        d_rdata_o  = d_rvalid_o ? ram_rdata_i : '0;
        f_rdata_o  = f_rvalid_o ? ram_rdata_i : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            if (d_win && !d_we_i)
                owner <= OWN_D_RD;
            else if (f_win)
                owner <= OWN_F_RD;
            else
                owner <= OWN_NONE;

            if (f_win || !f_req_i)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_ram_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned BE_W       = DATA_W / 8;

    logic              clk;
    logic              rst_n;
    logic              d_req_i;
    logic              d_we_i;
    logic [BE_W-1:0]   d_be_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              f_req_i;
    logic [ADDR_W-1:0] f_addr_i;
    logic              f_gnt_o;
    logic              f_rvalid_o;
    logic [DATA_W-1:0] f_rdata_o;
    logic              ram_en_o;
    logic              ram_we_o;
    logic [BE_W-1:0]   ram_be_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_be_i      (d_be_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .f_req_i     (f_req_i),
        .f_addr_i    (f_addr_i),
        .f_gnt_o     (f_gnt_o),
        .f_rvalid_o  (f_rvalid_o),
        .f_rdata_o   (f_rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending read owner (0 none, 1 data, 2 fetch) and how many
    // consecutive cycles fetch has been kept waiting.
    int          pend      = 0;
    logic [31:0] pend_addr = '0;
    int          fwait     = 0;
    bit          last_dg   = 0;
    bit          last_fg   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " d_gnt"},    32'(d_gnt_o),    '0);
        chk({tag, " f_gnt"},    32'(f_gnt_o),    '0);
        chk({tag, " d_rvalid"}, 32'(d_rvalid_o), '0);
        chk({tag, " f_rvalid"}, 32'(f_rvalid_o), '0);
        chk({tag, " d_rdata"},  d_rdata_o,       '0);
        chk({tag, " f_rdata"},  f_rdata_o,       '0);
        chk({tag, " ram_en"},   32'(ram_en_o),   '0);
        chk({tag, " ram_we"},   32'(ram_we_o),   '0);
        chk({tag, " ram_be"},   32'(ram_be_o),   '0);
        chk({tag, " ram_addr"}, ram_addr_o,      '0);
        chk({tag, " ram_wdata"}, ram_wdata_o,    '0);
    endtask

    // One clock cycle: inputs already set by caller, starting just after posedge.
    task automatic step();
        bit exp_fg, exp_dg;
        logic [31:0] exp_addr;
        ram_rdata_i = (pend != 0) ? mem_word(pend_addr) : $urandom();
        @(negedge clk);
        exp_fg = f_req_i && (!d_req_i || fwait >= int'(STARVE_MAX));
        exp_dg = d_req_i && !exp_fg;
        exp_addr = exp_dg ? d_addr_i : (exp_fg ? f_addr_i : 32'h0);
        chk("d_gnt",     32'(d_gnt_o),  32'(exp_dg));
        chk("f_gnt",     32'(f_gnt_o),  32'(exp_fg));
        chk("ram_en",    32'(ram_en_o), 32'(exp_dg | exp_fg));
        chk("ram_we",    32'(ram_we_o), 32'(exp_dg & d_we_i));
        chk("ram_be",    32'(ram_be_o), exp_dg ? 32'(d_be_i) : 32'h0);
        chk("ram_addr",  ram_addr_o,    exp_addr);
        chk("ram_wdata", ram_wdata_o,   exp_dg ? d_wdata_i : 32'h0);
        chk("d_rvalid",  32'(d_rvalid_o), 32'(pend == 1));
        chk("f_rvalid",  32'(f_rvalid_o), 32'(pend == 2));
        chk("d_rdata",   d_rdata_o, (pend == 1) ? mem_word(pend_addr) : 32'h0);
        chk("f_rdata",   f_rdata_o, (pend == 2) ? mem_word(pend_addr) : 32'h0);
        @(posedge clk);
        if (exp_dg && !d_we_i) begin
            pend = 1; pend_addr = d_addr_i;
        end else if (exp_fg) begin
            pend = 2; pend_addr = f_addr_i;
        end else begin
            pend = 0;
        end
        fwait   = (f_req_i && !exp_fg) ? fwait + 1 : 0;
        last_dg = exp_dg;
        last_fg = exp_fg;
        #1;
    endtask

    task automatic idle_inputs();
        d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        f_req_i = 0; f_addr_i = '0;
    endtask

    initial begin
        // Reset held with both ports requesting.
        rst_n = 0;
        idle_inputs();
        d_req_i = 1; d_addr_i = 32'h44; d_we_i = 1; d_be_i = '1; d_wdata_i = 32'hFFFF_FFFF;
        f_req_i = 1; f_addr_i = 32'h88;
        ram_rdata_i = 32'hCAFE_F00D;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) step();

        // Single data read at 0x10.
        d_req_i = 1; d_we_i = 0; d_be_i = '1; d_addr_i = 32'h10;
        step();
        idle_inputs();
        step();

        // Data write with partial byte enables.
        d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_wdata_i = 32'h0000BEEF; d_addr_i = 32'h20;
        step();
        idle_inputs();
        step();

        // Continuous contention: data x4, fetch, data x4, fetch.
        d_req_i = 1; d_we_i = 0; d_be_i = '1; f_req_i = 1;
        for (int i = 0; i < 11; i++) begin
            d_addr_i = 32'h100 + 32'(i * 4);
            f_addr_i = 32'h200 + 32'(i * 4);
            step();
        end
        idle_inputs();
        step();

        // Interleaved fetch then data reads.
        f_req_i = 1; f_addr_i = 32'h0;
        step();
        idle_inputs();
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h40;
        step();
        idle_inputs();
        step();

        // Build up fetch waiting, grant a data read, then reset the next cycle.
        d_req_i = 1; d_we_i = 0; f_req_i = 1; f_addr_i = 32'h300;
        for (int i = 0; i < 3; i++) begin
            d_addr_i = 32'h80 + 32'(i * 4);
            step();
        end
        d_addr_i = 32'h90;
        step();
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        chk_all_zero("mid_reset");
        pend = 0; fwait = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        step();
        d_req_i = 1; d_we_i = 0; f_req_i = 1; f_addr_i = 32'h400;
        for (int i = 0; i < 6; i++) begin
            d_addr_i = 32'hA0 + 32'(i * 4);
            step();
        end
        idle_inputs();
        step();

        // Random traffic; requests held until granted, addresses may wander.
        for (int i = 0; i < 400; i++) begin
            if (!d_req_i || last_dg) begin
                d_req_i   = ($urandom_range(0, 3) != 0);
                d_we_i    = 1'($urandom_range(0, 1));
                d_be_i    = 4'($urandom());
                d_wdata_i = $urandom();
                d_addr_i  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end else if ($urandom_range(0, 3) == 0) begin
                d_addr_i  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!f_req_i || last_fg) begin
                f_req_i  = 1'($urandom_range(0, 1));
                f_addr_i = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end else if ($urandom_range(0, 3) == 0) begin
                f_addr_i = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
